// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and widths for the I2S capture path
package i2s_pkg;

  localparam int FRAME_BITS = 6;
  localparam int SAMPLE_W   = 16;
  localparam int PAIR_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_capture_ctrl_sync_fifo.sv
// rtl/i2s_capture_ctrl_sync_fifo.sv - single-clock FIFO with flush, shared by RX and TX paths
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Head is presented combinationally; an empty FIFO shows zero.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // Storage array, written only; no reset needed since reads are gated by empty.
  always_ff @(posedge ck) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; flush returns the FIFO to empty.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// rtl/i2s_capture_ctrl.sv - frame-timed capture sequencer feeding a stereo-pair stream
module i2s_capture_ctrl
  import i2s_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CAPTURE_POSN = 1
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  ws,
  input  logic [FRAME_BITS-1:0] frame_posn,
  input  logic [SAMPLE_W-1:0]   left,
  input  logic [SAMPLE_W-1:0]   right,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           count,
  output logic [PAIR_W-1:0]     data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        sck_q;
  logic        tick;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_ws;

  // Word select is only observed upstream; sequencing is driven by frame_posn.
  assign unused_ws = ws;

  // One strobe per frame: the rising bit-clock edge at the capture position.
  assign tick = sck && !sck_q && (frame_posn == FRAME_BITS'(CAPTURE_POSN));

  assign fifo_pop = !fifo_empty && ready;
  assign valid    = !fifo_empty;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  // Bit-clock history for edge detection.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= sck;
    end
  end

  // Sequencer next state: abort dominates, start only honoured from IDLE.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = ARMED;
            remaining_d = count;
            ovf_d       = 1'b0;
          end
        end
        ARMED: begin
          // First frame after arming is partial, so it is skipped.
          if (tick) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) begin
              ovf_d = 1'b1;
            end
            // Frames are counted by time, dropped or not; zero means run forever.
            if (remaining_q == 16'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (remaining_q != 16'd0) begin
              remaining_d = remaining_q - 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state, frame counter, sticky overflow and done pulse.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({left, right}),
    .pop   (fifo_pop),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// tb/tb_i2s_capture_ctrl.sv - scoreboard bench for the I2S capture sequencer
module tb_i2s_capture_ctrl;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic [5:0]  frame_posn = 6'd0;
  logic [15:0] left = 16'h8234;
  logic [15:0] right = 16'h8235;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] count = 16'd0;
  logic        ready = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic        done;
  logic        overflow;

  int vectors = 0;
  int errs = 0;
  int words_rx = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];
  bit  exp_skip = 1'b0;
  int  exp_n = 0;
  bit  tick_next = 1'b0;

  i2s_capture_ctrl #(.DEPTH(8), .CAPTURE_POSN(1)) dut (
    .ck(ck), .rst_n(rst_n), .sck(sck), .ws(ws), .frame_posn(frame_posn),
    .left(left), .right(right), .start(start), .abort(abort), .count(count),
    .data(data), .valid(valid), .ready(ready), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 ck = ~ck;

  // I2S timing source: sck at half ck rate, 64 bit positions per frame.
  // Each capture-position rising edge feeds the expectation queue.
  initial begin
    forever begin
      @(posedge ck); #1;
      tick_next = 1'b0;
      if (sck) begin
        sck = 1'b0;
        frame_posn = frame_posn + 6'd1;
        if (frame_posn == 6'd0) begin
          left  = left + 16'd1;
          right = left + 16'd1;
        end
        ws = frame_posn[5];
      end else begin
        sck = 1'b1;
        if (frame_posn == 6'd1) begin
          tick_next = 1'b1;
          if (exp_skip) begin
            exp_skip = 1'b0;
          end else if (exp_n != 0) begin
            exp_q.push_back({left, right});
            if (exp_n > 0) exp_n--;
          end
        end
      end
    end
  end

  // Consumer side: scoreboard pop on each accepted word, hold-stable check.
  initial begin
    logic [31:0] held;
    logic [31:0] exp;
    bit hold_chk;
    hold_chk = 1'b0;
    held = '0;
    forever begin
      @(negedge ck);
      if (done) done_cnt++;
      if (hold_chk && valid) begin
        vectors++;
        if (data !== held) begin
          errs++;
          $display("FAIL hold_stable: data=%h required=%h", data, held);
        end
      end
      hold_chk = valid && !ready;
      held = data;
      if (valid && ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_word: data=%h required=none", data);
        end else begin
          exp = exp_q.pop_front();
          if (data !== exp) begin
            errs++;
            $display("FAIL word_data: data=%h required=%h", data, exp);
          end
        end
        words_rx++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
    $fatal(1);
  end

  task automatic wait_posn20();
    for (int i = 0; i < 200; i++) begin
      @(posedge ck); #2;
      if (frame_posn == 6'd20) break;
    end
  endtask

  task automatic do_start(input logic [15:0] c, input int n);
    wait_posn20();
    count = c; start = 1'b1; exp_skip = 1'b1; exp_n = n;
    @(posedge ck); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge ck);
      if (done) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin
      errs++;
      $display("FAIL %s_done_timeout: done=0 required=1", nm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #2;
    vectors += 5;
    if (data !== 32'd0) begin errs++; $display("FAIL reset_data: got %h required 0", data); end
    if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b required 0", valid); end
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b required 0", done); end
    if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc0;
    ready = 1'b1; words_rx = 0; dc0 = done_cnt;
    do_start(16'd3, 3);
    vectors++;
    if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_rise: got %b required 1", busy); end
    wait_done("basic");
    vectors++;
    if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_fall: got %b required 0", busy); end
    repeat (300) @(posedge ck);
    #2;
    vectors += 4;
    if (words_rx != 3) begin errs++; $display("FAIL basic_words: got %0d required 3", words_rx); end
    if (done_cnt - dc0 != 1) begin errs++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - dc0); end
    if (overflow !== 1'b0) begin errs++; $display("FAIL basic_overflow: got %b required 0", overflow); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL basic_missing: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    ready = 1'b0; words_rx = 0;
    do_start(16'd12, 12);
    wait_done("ovf");
    vectors += 3;
    if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    if (valid !== 1'b1) begin errs++; $display("FAIL ovf_valid: got %b required 1", valid); end
    if (exp_q.size() != 12) begin errs++; $display("FAIL ovf_frames: got %0d required 12", exp_q.size()); end
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    @(posedge ck); #2;
    ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ck);
      if (!valid) break;
    end
    repeat (2) @(posedge ck);
    #2;
    vectors += 3;
    if (words_rx != 8) begin errs++; $display("FAIL ovf_drain_words: got %0d required 8", words_rx); end
    if (valid !== 1'b0) begin errs++; $display("FAIL ovf_drain_valid: got %b required 0", valid); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL ovf_missing: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_continuous();
    int dc0;
    ready = 1'b1; words_rx = 0; dc0 = done_cnt;
    do_start(16'd0, -1);
    vectors++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL cont_ovf_clear: got %b required 0", overflow); end
    for (int i = 0; i < 2000; i++) begin
      @(posedge ck); #2;
      if (words_rx == 5) break;
    end
    abort = 1'b1; exp_n = 0;
    @(posedge ck); #2;
    abort = 1'b0;
    vectors += 2;
    if (busy !== 1'b0) begin errs++; $display("FAIL cont_abort_busy: got %b required 0", busy); end
    if (valid !== 1'b0) begin errs++; $display("FAIL cont_abort_valid: got %b required 0", valid); end
    repeat (300) @(posedge ck);
    #2;
    vectors += 3;
    if (words_rx != 5) begin errs++; $display("FAIL cont_words: got %0d required 5", words_rx); end
    if (done_cnt != dc0) begin errs++; $display("FAIL cont_no_done: got %0d required %0d", done_cnt, dc0); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL cont_missing: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_start_abort();
    bit busy_seen;
    int dc0;
    ready = 1'b1; words_rx = 0;
    wait_posn20();
    count = 16'd5; start = 1'b1; abort = 1'b1;
    @(posedge ck); #2;
    start = 1'b0; abort = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ck);
      if (busy) busy_seen = 1'b1;
    end
    vectors += 2;
    if (busy_seen !== 1'b0) begin errs++; $display("FAIL sa_busy: got 1 required 0"); end
    if (words_rx != 0) begin errs++; $display("FAIL sa_words: got %0d required 0", words_rx); end
    dc0 = done_cnt;
    do_start(16'd2, 2);
    for (int i = 0; i < 1000; i++) begin
      @(posedge ck); #2;
      if (words_rx == 1) break;
    end
    wait_posn20();
    count = 16'd7; start = 1'b1;
    @(posedge ck); #2;
    start = 1'b0;
    wait_done("rerun");
    repeat (300) @(posedge ck);
    #2;
    vectors += 4;
    if (words_rx != 2) begin errs++; $display("FAIL rerun_words: got %0d required 2", words_rx); end
    if (done_cnt - dc0 != 1) begin errs++; $display("FAIL rerun_done_pulses: got %0d required 1", done_cnt - dc0); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rerun_busy: got %b required 0", busy); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL rerun_missing: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_full_pop();
    ready = 1'b0; words_rx = 0;
    do_start(16'd9, 9);
    for (int i = 0; i < 2000; i++) begin
      @(posedge ck); #2;
      if (tick_next && exp_q.size() == 9) break;
    end
    vectors++;
    if (valid !== 1'b1) begin errs++; $display("FAIL full_pop_prefill: got %b required 1", valid); end
    ready = 1'b1;
    wait_done("full_pop");
    repeat (50) @(posedge ck);
    #2;
    vectors += 3;
    if (words_rx != 9) begin errs++; $display("FAIL full_pop_words: got %0d required 9", words_rx); end
    if (overflow !== 1'b0) begin errs++; $display("FAIL full_pop_overflow: got %b required 0", overflow); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL full_pop_missing: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int dc0;
    ready = 1'b0; words_rx = 0;
    do_start(16'd4, 4);
    for (int i = 0; i < 1000; i++) begin
      @(posedge ck); #2;
      if (exp_q.size() == 2) break;
    end
    repeat (3) @(posedge ck);
    dc0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (data !== 32'd0) begin errs++; $display("FAIL midrst_data: got %h required 0", data); end
    if (valid !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b required 0", valid); end
    if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errs++; $display("FAIL midrst_done: got %b required 0", done); end
    @(posedge ck); #3;
    rst_n = 1'b1;
    exp_q.delete(); exp_n = 0; exp_skip = 1'b0;
    ready = 1'b1; words_rx = 0;
    do_start(16'd2, 2);
    wait_done("post_rst");
    repeat (50) @(posedge ck);
    #2;
    vectors += 3;
    if (words_rx != 2) begin errs++; $display("FAIL post_rst_words: got %0d required 2", words_rx); end
    if (done_cnt - dc0 != 1) begin errs++; $display("FAIL post_rst_done_pulses: got %0d required 1", done_cnt - dc0); end
    if (exp_q.size() != 0) begin errs++; $display("FAIL post_rst_missing: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_continuous();
    test_start_abort();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/i2s_capture_ctrl.md
# i2s_capture_ctrl

Sequencer for the microphone capture path. It watches the I2S frame timing (`sck`, `ws`, `frame_posn`) and, on command, latches a programmed number of stereo sample pairs from the I2S receiver's `left`/`right` outputs. Captured pairs are buffered in a small FIFO and handed to the downstream consumer over a valid/ready stream. It sits between the I2S clock/RX blocks and whatever drains audio: the DSP, UART or SPI bridge.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, ≥2.
- `CAPTURE_POSN`, 1: `frame_posn` value at which `left`/`right` are sampled. Both words are stable at this point.
- `ck`  in  1  system clock; also clocks the I2S clock generator.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sck`  in  1  I2S bit clock, generated synchronously from `ck`.
- `ws`  in  1  word select (unused for sequencing; monitored only).
- `frame_posn`  in  6  bit position within the 64-bit frame.
- `left`, `right`  in  16 each  receiver outputs.
- `start`  in  1  one-cycle pulse: begin a capture of `count` frames.
- `abort`  in  1  one-cycle pulse: stop capture, flush FIFO.
- `count`  in  16  frames to capture; sampled on `start`; 0 means continuous.
- `data`  out  32  `{left, right}` of the FIFO head.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `busy`  out  1  FSM not IDLE.
- `done`  out  1  one-cycle pulse when the final frame is written.
- `overflow`  out  1  sticky; a frame arrived while the FIFO was full.

## Operation
- Frame strobe: `sck_q` registers `sck`. The strobe `tick` is `sck && !sck_q && frame_posn == CAPTURE_POSN`, giving one `ck` cycle per frame.
- FSM states:
  - IDLE → ARMED on `start`. `start` latches `count` into `remaining` and clears `overflow`.
  - ARMED → RUN on the first `tick`. No sample is taken on this tick; the first frame is partial.
  - RUN: on each `tick`, push `{left, right}`. If `remaining == 1`, pulse `done` and go to IDLE; otherwise decrement `remaining`. When `count == 0` at latch time, `remaining` never decrements and RUN persists until `abort`.
- Full FIFO on `tick`: the frame is dropped, `overflow` is set, and `remaining` still decrements. The count is frame-time based.
- `abort` in any state: go to IDLE, reset the FIFO pointers (`valid` = 0 next cycle). `overflow` is kept.
- `start` while not IDLE is ignored.
- `start` and `abort` in the same cycle: `abort` wins.
- Push and pop in the same cycle are both honoured. If the FIFO was full, the pop frees a slot first, so the push succeeds and no overflow is raised.
- IDLE drains: the FIFO keeps presenting data after `done` until it is empty.
- Occupancy counter width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- All outputs reset asynchronously to: `data` = 0, `valid` = 0, `busy` = 0, `done` = 0, `overflow` = 0. FSM resets to IDLE, FIFO to empty.
- `busy` rises the cycle after `start`.
- Latency from `tick` to `valid` (FIFO previously empty) is 1 cycle. The write registers on the `tick` edge, and `data` is the registered/array head.
- `done` asserts in the cycle after the final `tick`, together with `busy` falling.
- `data` must be held stable while `valid && !ready`.
- Reset asserted mid-capture: everything clears immediately; no `done` pulse.

## Structure
- Package `i2s_pkg`:
  - FSM state enum {IDLE, ARMED, RUN}.
  - `FRAME_BITS` = 6.
  - `SAMPLE_W` = 16.
  - `PAIR_W` = 32.
- Sub-module `sync_fifo`: single clock, parameterised width/depth, with `flush` input, `full`/`empty`/`push`/`pop`. It is reusable by the TX side later.
- The controller holds the edge detect, FSM, `remaining` counter and overflow flag.

## Test plan
- `count` = 3, `ready` held 1, incrementing `left` = 0x8234, 0x8235…: exactly 3 words appear with `right` = `left` + 1. `done` pulses once, `busy` is 0 afterwards, `overflow` = 0.
- `count` = 12, `DEPTH` = 8, `ready` = 0 until `done`: FIFO holds the first 8 pairs in order. `overflow` = 1. Draining yields 8 words, then `valid` = 0.
- `count` = 0 (continuous), `abort` after 5 frames: 5 words are output, no `done`, `busy` = 0 one cycle after `abort`, FIFO flushed.
- `start` and `abort` asserted together from IDLE: stays IDLE, `busy` never rises. A `start` pulsed during RUN does not reload `remaining`.
- FIFO full with `ready` = 1 on the `tick` cycle: the push is accepted and `overflow` stays 0.
- `rst_n` dropped mid-RUN for 1 cycle: all outputs 0 asynchronously. After release a new `start` with `count` = 2 completes normally.
